// File: rtl/uart_bridge_pkg.sv
// Shared constants and FSM encodings for the UART-to-register-file bridge.
package uart_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_EXEC,
        ST_RESP
    } bridge_state_e;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_WAIT,
        SQ_GAP
    } seq_state_e;

    // Number of whole bytes needed to carry a field of the given bit width.
    function automatic int unsigned bytes_for(input int unsigned bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// Shifts a left-justified byte vector out to the UART transmitter, MSB byte
// first, one tx_start pulse per byte once the transmitter reports idle.
// A load is only accepted while no transfer is in flight.
module uart_tx_sequencer
    import uart_bridge_pkg::*;
#(
    parameter int unsigned NBYTES = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [NBYTES*8-1:0] data_i,
    input  logic [CNT_W-1:0]    count_i,
    input  logic                tx_busy_i,
    output logic                tx_start_o,
    output logic [7:0]          tx_byte_o,
    output logic                busy_o
);

    seq_state_e          state_q, state_d;
    logic [NBYTES*8-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          byte_q, byte_d;
    logic                start_q, start_d;

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SQ_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            start_q <= start_d;
        end
    end

    // Per byte: wait for transmitter idle, pulse start, then one gap cycle so
    // the transmitter's busy flag is visible before the next byte is offered.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        start_d = 1'b0;
        case (state_q)
            SQ_IDLE: begin
                if (load_i && (count_i != '0)) begin
                    shreg_d = data_i;
                    cnt_d   = count_i;
                    state_d = SQ_WAIT;
                end
            end
            SQ_WAIT: begin
                if (!tx_busy_i) begin
                    start_d = 1'b1;
                    byte_d  = shreg_q[NBYTES*8-1 -: 8];
                    shreg_d = shreg_q << 8;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = SQ_GAP;
                end
            end
            SQ_GAP: begin
                state_d = (cnt_q == '0) ? SQ_IDLE : SQ_WAIT;
            end
            default: state_d = SQ_IDLE;
        endcase
    end

    assign tx_start_o = start_q;
    assign tx_byte_o  = byte_q;
    assign busy_o     = (state_q != SQ_IDLE);

endmodule

// File: rtl/uart_mem_bridge.sv
// UART command parser in front of a DEPTH x DATA_W register file.
// Frames: CMD, address bytes, (write) data bytes, MSB first; replies ACK/NAK
// or read data. Optional build macro UART_MEM_BRIDGE_CHECKSUM_EN adds an XOR
// checksum byte to every frame and an XOR trailer to read replies.
module uart_mem_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic              sys_clock,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_strobe,
    output logic              error
);

    localparam int unsigned DB = DATA_W / 8;
    localparam int unsigned AB = bytes_for(ADDR_W);
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    localparam int unsigned CHK_EN = 1;
    localparam bridge_state_e ST_FRAME_END = ST_CHK;
`else
    localparam int unsigned CHK_EN = 0;
    localparam bridge_state_e ST_FRAME_END = ST_EXEC;
`endif
    localparam int unsigned NB     = DB + CHK_EN;
    localparam int unsigned SEQ_W  = NB * 8;
    localparam int unsigned SCNT_W = $clog2(NB + 1);
    localparam int unsigned MAXB   = (AB > DB) ? AB : DB;
    localparam int unsigned FCNT_W = $clog2(MAXB + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    bridge_state_e     state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              wr_q, wr_d;
    logic              seq_load;
    logic [SEQ_W-1:0]  seq_data;
    logic [SCNT_W-1:0] seq_count;
    logic              seq_busy;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_word;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;

    function automatic logic [7:0] word_xor(input logic [DATA_W-1:0] w);
        logic [7:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < DB; i++) acc ^= w[i*8 +: 8];
        return acc;
    endfunction
`endif

    assign mem_word = mem[addr_q];

    // Control registers; reset aborts any frame or reply in progress.
    always_ff @(posedge sys_clock) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            fcnt_q    <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            rd_data_q <= '0;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            fcnt_q    <= fcnt_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            rd_data_q <= mem[rd_addr];
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    // Register file write port; contents survive reset.
    always_ff @(posedge sys_clock) begin
        if (!rst && (state_q == ST_EXEC) && is_wr_q) mem[addr_q] <= data_q;
    end

    // Frame parsing, timeout, execution and reply scheduling.
    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        fcnt_d    = fcnt_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;
        wr_d      = 1'b0;
        seq_load  = 1'b0;
        seq_data  = '0;
        seq_count = '0;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                fcnt_d = '0;
                tmo_d  = '0;
                if (rx_valid) begin
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
                    chk_d = rx_byte;
`endif
                    if (rx_byte == CMD_WRITE) begin
                        is_wr_d = 1'b1;
                        state_d = ST_ADDR;
                    end else if (rx_byte == CMD_READ) begin
                        is_wr_d = 1'b0;
                        state_d = ST_ADDR;
                    end else begin
                        err_d                   = 1'b1;
                        seq_load                = 1'b1;
                        seq_data[SEQ_W-1 -: 8]  = RSP_NAK;
                        seq_count               = SCNT_W'(1);
                    end
                end
            end
            ST_ADDR, ST_DATA, ST_CHK: begin
                if (rx_valid) begin
                    tmo_d = '0;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
                    chk_d = chk_q ^ rx_byte;
`endif
                    case (state_q)
                        ST_ADDR: begin
                            // Truncation drops address bits above ADDR_W.
                            addr_d = ADDR_W'({addr_q, rx_byte});
                            fcnt_d = fcnt_q + FCNT_W'(1);
                            if (fcnt_q == FCNT_W'(AB - 1)) begin
                                fcnt_d  = '0;
                                state_d = is_wr_q ? ST_DATA : ST_FRAME_END;
                            end
                        end
                        ST_DATA: begin
                            data_d = DATA_W'({data_q, rx_byte});
                            fcnt_d = fcnt_q + FCNT_W'(1);
                            if (fcnt_q == FCNT_W'(DB - 1)) begin
                                fcnt_d  = '0;
                                state_d = ST_FRAME_END;
                            end
                        end
                        default: begin
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
                            if (rx_byte == chk_q) begin
                                state_d = ST_EXEC;
                            end else begin
                                state_d                = ST_IDLE;
                                err_d                  = 1'b1;
                                seq_load               = 1'b1;
                                seq_data[SEQ_W-1 -: 8] = RSP_NAK;
                                seq_count              = SCNT_W'(1);
                            end
`else
                            state_d = ST_IDLE;
`endif
                        end
                    endcase
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_EXEC: begin
                err_d    = rx_valid;
                state_d  = ST_RESP;
                seq_load = 1'b1;
                if (is_wr_q) begin
                    wr_d                   = 1'b1;
                    seq_data[SEQ_W-1 -: 8] = RSP_ACK;
                    seq_count              = SCNT_W'(1);
                end else begin
                    seq_data[SEQ_W-1 -: DATA_W] = mem_word;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
                    seq_data[7:0] = word_xor(mem_word);
`endif
                    seq_count = SCNT_W'(NB);
                end
            end
            ST_RESP: begin
                err_d = rx_valid;
                if (!seq_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    uart_tx_sequencer #(
        .NBYTES (NB),
        .CNT_W  (SCNT_W)
    ) u_tx_seq (
        .clk_i      (sys_clock),
        .rst_i      (rst),
        .load_i     (seq_load),
        .data_i     (seq_data),
        .count_i    (seq_count),
        .tx_busy_i  (tx_busy),
        .tx_start_o (tx_start),
        .tx_byte_o  (tx_byte),
        .busy_o     (seq_busy)
    );

    assign rd_data   = rd_data_q;
    assign wr_strobe = wr_q;
    assign error     = err_q;

endmodule
